// File: rtl/adder_serial_ctrl_if.sv
// Handshake bundle for the nibble-serial adder: operand request channel,
// result channel and a busy indicator.
interface adder_serial_ctrl_if #(
   parameter int unsigned WIDTH = 16
);
   logic             start_valid;
   logic             start_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;

   modport master (
      output start_valid, a, b, cin, res_ready,
      input  start_ready, res_valid, sum, cout, busy
   );

   modport slave (
      input  start_valid, a, b, cin, res_ready,
      output start_ready, res_valid, sum, cout, busy
   );
endinterface

// File: rtl/adder_serial_ctrl.sv
// Nibble-serial WIDTH-bit adder: one shared 4-bit ripple adder is stepped
// across the operands LSB nibble first, with the carry held in a register.

// Plain 4-bit ripple adder shared by every nibble step.
module adder_4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);
   logic [4:0] w_total;

   // Single 5-bit add gives both the nibble sum and its carry out.
   assign w_total = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
   assign sum     = w_total[3:0];
   assign cout    = w_total[4];
endmodule

module adder_serial_ctrl #(
   parameter int unsigned WIDTH = 16
) (
   input logic                    i_clk,
   input logic                    i_rst_n,
   adder_serial_ctrl_if.slave     io_bus
);
   localparam int unsigned NIB = WIDTH / 4;
   localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   state_e           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic             r_c;
   logic             r_cout;
   logic             r_res_valid;
   logic [CW-1:0]    r_cnt;

   logic [3:0]       w_nib_sum;
   logic             w_nib_cout;
   logic [WIDTH-1:0] w_nib_top;
   logic [WIDTH-1:0] w_sum_shift;

   adder_4bit u_adder (
      .a    (r_a[3:0]),
      .b    (r_b[3:0]),
      .cin  (r_c),
      .sum  (w_nib_sum),
      .cout (w_nib_cout)
   );

   // New nibble enters at the top of the result; after NIB steps nibble 0 sits at [3:0].
   // Built with shifts so WIDTH=4 needs no zero-width slice.
   assign w_nib_top   = WIDTH'(w_nib_sum) << (WIDTH - 4);
   assign w_sum_shift = (r_sum >> 4) | w_nib_top;

   // Sequencer: accept operands, step the adder NIB times, hold the result until taken.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= StIdle;
         r_a         <= '0;
         r_b         <= '0;
         r_sum       <= '0;
         r_c         <= 1'b0;
         r_cout      <= 1'b0;
         r_res_valid <= 1'b0;
         r_cnt       <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (io_bus.start_valid) begin
                  r_a     <= io_bus.a;
                  r_b     <= io_bus.b;
                  r_c     <= io_bus.cin;
                  r_cnt   <= '0;
                  r_state <= StRun;
               end
            end
            StRun: begin
               r_a   <= r_a >> 4;
               r_b   <= r_b >> 4;
               r_sum <= w_sum_shift;
               r_c   <= w_nib_cout;
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == CW'(NIB - 1)) begin
                  r_cout      <= w_nib_cout;
                  r_res_valid <= 1'b1;
                  r_state     <= StDone;
               end
            end
            StDone: begin
               // No bypass to IDLE-accept here: a new start waits one cycle.
               if (io_bus.res_ready) begin
                  r_res_valid <= 1'b0;
                  r_state     <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   // Status decoded from state only; result outputs come straight from registers.
   assign io_bus.start_ready = (r_state == StIdle);
   assign io_bus.busy        = (r_state != StIdle);
   assign io_bus.res_valid   = r_res_valid;
   assign io_bus.sum         = r_sum;
   assign io_bus.cout        = r_cout;
endmodule

// File: tb/tb_adder_serial_ctrl.sv
// Directed and random checks of the nibble-serial adder at WIDTH 16, 4 and 32.
module tb_adder_serial_ctrl;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;
   int   cyc;

   adder_serial_ctrl_if #(.WIDTH(16)) b16 ();
   adder_serial_ctrl_if #(.WIDTH(4))  b4 ();
   adder_serial_ctrl_if #(.WIDTH(32)) b32 ();

   adder_serial_ctrl #(.WIDTH(16)) u_dut16 (.i_clk(clk), .i_rst_n(rst_n), .io_bus(b16));
   adder_serial_ctrl #(.WIDTH(4))  u_dut4  (.i_clk(clk), .i_rst_n(rst_n), .io_bus(b4));
   adder_serial_ctrl #(.WIDTH(32)) u_dut32 (.i_clk(clk), .i_rst_n(rst_n), .io_bus(b32));

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [15:0] sum;
      logic        cout;
   } vec_t;

   vec_t vecs[8];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Watchdog so a stuck handshake can never hang the run.
   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One 16-bit transaction; busy_ok tracks busy=1 on every cycle from accept to result.
   task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic c,
                        output logic [15:0] s, output logic co, output int lat,
                        output logic busy_ok, output logic idle_after);
      @(negedge clk);
      b16.a = a; b16.b = b; b16.cin = c; b16.start_valid = 1'b1;
      @(negedge clk);
      b16.start_valid = 1'b0;
      lat = 0;
      busy_ok = b16.busy;
      while (!b16.res_valid && lat < 40) begin
         @(negedge clk);
         lat++;
         busy_ok = busy_ok & b16.busy;
      end
      s = b16.sum; co = b16.cout;
      b16.res_ready = 1'b1;
      @(negedge clk);
      b16.res_ready = 1'b0;
      idle_after = b16.start_ready & ~b16.busy;
   endtask

   task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic c,
                       output logic [3:0] s, output logic co, output int lat);
      @(negedge clk);
      b4.a = a; b4.b = b; b4.cin = c; b4.start_valid = 1'b1;
      @(negedge clk);
      b4.start_valid = 1'b0;
      lat = 0;
      while (!b4.res_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      s = b4.sum; co = b4.cout;
      b4.res_ready = 1'b1;
      @(negedge clk);
      b4.res_ready = 1'b0;
   endtask

   task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic c,
                        output logic [31:0] s, output logic co, output int lat);
      @(negedge clk);
      b32.a = a; b32.b = b; b32.cin = c; b32.start_valid = 1'b1;
      @(negedge clk);
      b32.start_valid = 1'b0;
      lat = 0;
      while (!b32.res_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      s = b32.sum; co = b32.cout;
      b32.res_ready = 1'b1;
      @(negedge clk);
      b32.res_ready = 1'b0;
   endtask

   initial begin
      logic [15:0] s16;
      logic [3:0]  s4;
      logic [31:0] s32;
      logic        co;
      logic        busy_ok;
      logic        idle_after;
      logic [16:0] exp17;
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rc;
      int          lat;
      int          acc_cyc;
      int          prev_acc;
      int          wait_n;

      vecs[0] = '{16'h0002, 16'h0005, 1'b0, 16'h0007, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
      vecs[2] = '{16'h8888, 16'h8888, 1'b1, 16'h1111, 1'b1};
      vecs[3] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
      vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
      vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
      vecs[6] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0};
      vecs[7] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};

      n_checks = 0;
      n_errors = 0;
      cyc      = 0;
      rst_n    = 1'b0;
      b16.start_valid = 1'b0; b16.a = '0; b16.b = '0; b16.cin = 1'b0; b16.res_ready = 1'b0;
      b4.start_valid  = 1'b0; b4.a  = '0; b4.b  = '0; b4.cin  = 1'b0; b4.res_ready  = 1'b0;
      b32.start_valid = 1'b0; b32.a = '0; b32.b = '0; b32.cin = 1'b0; b32.res_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      chk("reset_sum", 64'(b16.sum), 64'h0);
      chk("reset_cout", 64'(b16.cout), 64'h0);
      chk("reset_res_valid", 64'(b16.res_valid), 64'h0);
      chk("reset_busy", 64'(b16.busy), 64'h0);
      chk("reset_start_ready", 64'(b16.start_ready), 64'h1);

      // Table-driven 16-bit additions.
      for (int i = 0; i < 8; i++) begin
         run16(vecs[i].a, vecs[i].b, vecs[i].cin, s16, co, lat, busy_ok, idle_after);
         chk($sformatf("vec%0d_sum", i), 64'(s16), 64'(vecs[i].sum));
         chk($sformatf("vec%0d_cout", i), 64'(co), 64'(vecs[i].cout));
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
         chk($sformatf("vec%0d_busy", i), 64'(busy_ok), 64'h1);
         chk($sformatf("vec%0d_idle_after", i), 64'(idle_after), 64'h1);
      end

      // Backpressure: result held, stray start ignored and not queued.
      @(negedge clk);
      b16.a = 16'h1111; b16.b = 16'h2222; b16.cin = 1'b0; b16.start_valid = 1'b1;
      @(negedge clk);
      b16.start_valid = 1'b0;
      wait_n = 0;
      while (!b16.res_valid && wait_n < 40) begin
         @(negedge clk);
         wait_n++;
      end
      chk("bp_valid", 64'(b16.res_valid), 64'h1);
      for (int k = 0; k < 5; k++) begin
         if (k == 1) begin
            b16.a = 16'h0F0F; b16.b = 16'h0101; b16.cin = 1'b1; b16.start_valid = 1'b1;
         end
         if (k == 2) b16.start_valid = 1'b0;
         @(negedge clk);
         chk($sformatf("bp%0d_sum", k), 64'(b16.sum), 64'h3333);
         chk($sformatf("bp%0d_cout", k), 64'(b16.cout), 64'h0);
         chk($sformatf("bp%0d_start_ready", k), 64'(b16.start_ready), 64'h0);
         chk($sformatf("bp%0d_res_valid", k), 64'(b16.res_valid), 64'h1);
      end
      b16.res_ready = 1'b1;
      @(negedge clk);
      b16.res_ready = 1'b0;
      chk("bp_release_start_ready", 64'(b16.start_ready), 64'h1);
      chk("bp_release_res_valid", 64'(b16.res_valid), 64'h0);
      @(negedge clk);
      chk("bp_not_queued_busy", 64'(b16.busy), 64'h0);
      chk("bp_sum_kept", 64'(b16.sum), 64'h3333);

      // Reset two cycles into a computation: outputs clear without a clock edge.
      @(negedge clk);
      b16.a = 16'h1234; b16.b = 16'h4321; b16.cin = 1'b0; b16.start_valid = 1'b1;
      @(negedge clk);
      b16.start_valid = 1'b0;
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mid_sum", 64'(b16.sum), 64'h0);
      chk("rst_mid_cout", 64'(b16.cout), 64'h0);
      chk("rst_mid_res_valid", 64'(b16.res_valid), 64'h0);
      chk("rst_mid_busy", 64'(b16.busy), 64'h0);
      chk("rst_mid_start_ready", 64'(b16.start_ready), 64'h1);
      @(negedge clk);
      rst_n = 1'b1;
      run16(16'h0009, 16'h0001, 1'b0, s16, co, lat, busy_ok, idle_after);
      chk("post_rst_sum", 64'(s16), 64'h000A);
      chk("post_rst_cout", 64'(co), 64'h0);
      chk("post_rst_latency", 64'(lat), 64'd4);

      // Back-to-back random operands with the consumer always ready.
      @(negedge clk);
      b16.res_ready = 1'b1;
      prev_acc = 0;
      for (int i = 0; i < 200; i++) begin
         wait_n = 0;
         while (!b16.start_ready && wait_n < 40) begin
            @(negedge clk);
            wait_n++;
         end
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom_range(0, 1));
         exp17 = {1'b0, ra} + {1'b0, rb} + {16'h0000, rc};
         b16.a = ra; b16.b = rb; b16.cin = rc; b16.start_valid = 1'b1;
         acc_cyc = cyc;
         if (i > 0) chk($sformatf("rnd%0d_interval", i), 64'(acc_cyc - prev_acc), 64'd6);
         prev_acc = acc_cyc;
         @(negedge clk);
         b16.start_valid = 1'b0;
         wait_n = 0;
         while (!b16.res_valid && wait_n < 40) begin
            @(negedge clk);
            wait_n++;
         end
         chk($sformatf("rnd%0d_sum", i), 64'(b16.sum), 64'(exp17[15:0]));
         chk($sformatf("rnd%0d_cout", i), 64'(b16.cout), 64'(exp17[16]));
         @(negedge clk);
      end
      b16.res_ready = 1'b0;

      // Parameter corners: single-nibble and eight-nibble operands.
      run4(4'hF, 4'h1, 1'b0, s4, co, lat);
      chk("w4_a_sum", 64'(s4), 64'h0);
      chk("w4_a_cout", 64'(co), 64'h1);
      chk("w4_a_latency", 64'(lat), 64'd1);
      run4(4'h5, 4'h2, 1'b0, s4, co, lat);
      chk("w4_b_sum", 64'(s4), 64'h7);
      chk("w4_b_cout", 64'(co), 64'h0);
      run4(4'h7, 4'h8, 1'b1, s4, co, lat);
      chk("w4_c_sum", 64'(s4), 64'h0);
      chk("w4_c_cout", 64'(co), 64'h1);

      run32(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, s32, co, lat);
      chk("w32_a_sum", 64'(s32), 64'h0);
      chk("w32_a_cout", 64'(co), 64'h1);
      chk("w32_a_latency", 64'(lat), 64'd8);
      run32(32'h1234_5678, 32'h1111_1111, 1'b0, s32, co, lat);
      chk("w32_b_sum", 64'(s32), 64'h2345_6789);
      chk("w32_b_cout", 64'(co), 64'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
